x2050_lsseq: RTL and testbench

X2050_LSSEQ -- requirements
Module: x2050_lsseq

---
 rtl/x2050_lsseq.sv | 150 +++++++++++++++
 tb/tb_x2050_lsseq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/x2050_lsseq.sv
// x2050_lsseq: local-storage multi-register sequencer for LM/STM-class ops.
// Walks register numbers from J to END (4-bit wrap), issuing one local-storage
// request per register with a one-cycle gap between requests. Every non-reset
// state change is qualified by the ROS cycle advance.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no sequence; o_count holds result of the last sequence
// REQ   | o_ls_addr/o_ls_valid presented, waiting for i_ls_ack
// STEP  | one-advance gap after an accepted request, before the next REQ
// DONE  | o_done asserted for one advance, then back to IDLE
module x2050_lsseq #(
    parameter logic [1:0] LS_BANK            = 2'b00,
    parameter logic       IDLE_ON_ABORT_DONE = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ros_advance,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [3:0] i_j_reg,
    input  logic [3:0] i_end_reg,
    input  logic       i_ls_ack,
    output logic [5:0] o_ls_addr,
    output logic       o_ls_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic [4:0] o_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cur_q, cur_d;
    logic [3:0] last_q, last_d;
    logic [5:0] addr_q, addr_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] count_q, count_d;

    // Next-state and registered-output computation; everything holds without an advance.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        count_d = count_q;

        if (i_ros_advance) begin
            // The completion pulse lasts exactly one advancing cycle.
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // Abort together with start in IDLE suppresses the start.
                    if (i_start && !i_abort) begin
                        cur_d   = i_j_reg;
                        last_d  = i_end_reg;
                        count_d = 5'd0;
                        busy_d  = 1'b1;
                        valid_d = 1'b1;
                        addr_d  = {LS_BANK, i_j_reg};
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (i_abort) begin
                        // Abort wins over a simultaneous ack; that transfer is not counted.
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = IDLE_ON_ABORT_DONE;
                    end else if (i_ls_ack) begin
                        count_d = count_q + 5'd1;
                        valid_d = 1'b0;
                        if (cur_q != last_q) begin
                            cur_d   = cur_q + 4'd1;
                            state_d = STEP;
                        end else begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                STEP: begin
                    if (i_abort) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = IDLE_ON_ABORT_DONE;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = {LS_BANK, cur_q};
                        state_d = REQ;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (i_abort) begin
                        done_d = IDLE_ON_ABORT_DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset to a fresh IDLE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cur_q   <= 4'd0;
            last_q  <= 4'd0;
            addr_q  <= 6'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign o_ls_addr  = addr_q;
    assign o_ls_valid = valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_count    = count_q;

endmodule

// File: tb/tb_x2050_lsseq.sv
// Directed bench for x2050_lsseq: two instances share stimulus, one with the
// default bank and one with LS_BANK=2'b10.
module tb_x2050_lsseq;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_ros_advance;
    logic       i_start;
    logic       i_abort;
    logic [3:0] i_j_reg;
    logic [3:0] i_end_reg;
    logic       i_ls_ack;

    logic [5:0] a_addr, b_addr;
    logic       a_valid, b_valid, a_busy, b_busy, a_done, b_done;
    logic [4:0] a_count, b_count;

    int checks   = 0;
    int failures = 0;

    logic [5:0] obs_q[$];
    int         done_cnt;
    int         back2back;

    x2050_lsseq dut_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_ros_advance(i_ros_advance),
        .i_start(i_start), .i_abort(i_abort), .i_j_reg(i_j_reg),
        .i_end_reg(i_end_reg), .i_ls_ack(i_ls_ack),
        .o_ls_addr(a_addr), .o_ls_valid(a_valid), .o_busy(a_busy),
        .o_done(a_done), .o_count(a_count)
    );

    x2050_lsseq #(.LS_BANK(2'b10)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_ros_advance(i_ros_advance),
        .i_start(i_start), .i_abort(i_abort), .i_j_reg(i_j_reg),
        .i_end_reg(i_end_reg), .i_ls_ack(i_ls_ack),
        .o_ls_addr(b_addr), .o_ls_valid(b_valid), .o_busy(b_busy),
        .o_done(b_done), .o_count(b_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Start a sequence with ack always high and advance always high; record
    // every address presented while valid, done pulses and back-to-back valids.
    task automatic run_seq(input logic [3:0] j, input logic [3:0] e);
        logic prev_valid;
        obs_q.delete();
        done_cnt  = 0;
        back2back = 0;
        prev_valid = 1'b0;
        i_j_reg = j; i_end_reg = e; i_start = 1'b1; i_ls_ack = 1'b1;
        i_ros_advance = 1'b1; i_abort = 1'b0;
        tick();
        i_start   = 1'b0;
        i_j_reg   = ~j;
        i_end_reg = ~e;
        for (int c = 0; c < 80; c++) begin
            if (a_valid) obs_q.push_back(a_addr);
            if (a_valid && prev_valid) back2back++;
            if (a_done) done_cnt++;
            prev_valid = a_valid;
            if (!a_busy) break;
            tick();
        end
        chk("seq_finished", {31'd0, a_busy}, 32'd0);
    endtask

    initial begin
        logic [5:0] exp_addr[$];

        i_reset = 1'b1; i_ros_advance = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_j_reg = 4'd0; i_end_reg = 4'd0; i_ls_ack = 1'b0;
        #12;
        chk("rst_addr",  {26'd0, a_addr},  32'd0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_busy",  {31'd0, a_busy},  32'd0);
        chk("rst_done",  {31'd0, a_done},  32'd0);
        chk("rst_count", {27'd0, a_count}, 32'd0);
        i_reset = 1'b0;
        tick();

        // j=3..5
        run_seq(4'd3, 4'd5);
        exp_addr = '{6'h03, 6'h04, 6'h05};
        chk("s1_n", obs_q.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < obs_q.size(); k++)
            chk($sformatf("s1_addr%0d", k), {26'd0, obs_q[k]}, {26'd0, exp_addr[k]});
        chk("s1_done", done_cnt, 1);
        chk("s1_gap", back2back, 0);
        chk("s1_count", {27'd0, a_count}, 32'd3);

        // wrap 14->1
        run_seq(4'd14, 4'd1);
        exp_addr = '{6'h0E, 6'h0F, 6'h00, 6'h01};
        chk("s2_n", obs_q.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < obs_q.size(); k++)
            chk($sformatf("s2_addr%0d", k), {26'd0, obs_q[k]}, {26'd0, exp_addr[k]});
        chk("s2_count", {27'd0, a_count}, 32'd4);

        // full 16 transfers
        run_seq(4'd7, 4'd6);
        chk("s3_n", obs_q.size(), 16);
        if (obs_q.size() == 16) begin
            chk("s3_first", {26'd0, obs_q[0]},  32'h07);
            chk("s3_mid",   {26'd0, obs_q[8]},  32'h0F);
            chk("s3_wrap",  {26'd0, obs_q[9]},  32'h00);
            chk("s3_last",  {26'd0, obs_q[15]}, 32'h06);
        end
        chk("s3_count", {27'd0, a_count}, 32'd16);
        chk("s3_done", done_cnt, 1);

        // j=end=9, delayed ack and toggling advance
        i_j_reg = 4'd9; i_end_reg = 4'd9; i_start = 1'b1; i_ls_ack = 1'b0;
        i_ros_advance = 1'b1;
        tick();
        i_start = 1'b0; i_j_reg = 4'd2; i_end_reg = 4'd3;
        for (int k = 0; k < 3; k++) begin
            i_ros_advance = k[0];
            tick();
            chk($sformatf("s4_valid%0d", k), {31'd0, a_valid}, 32'd1);
            chk($sformatf("s4_addr%0d", k), {26'd0, a_addr}, 32'h09);
        end
        i_ros_advance = 1'b0; i_ls_ack = 1'b1; i_start = 1'b1;
        tick();
        chk("s4_frozen_valid", {31'd0, a_valid}, 32'd1);
        chk("s4_frozen_count", {27'd0, a_count}, 32'd0);
        i_ros_advance = 1'b1;
        tick();
        i_start = 1'b0;
        chk("s4_done", {31'd0, a_done}, 32'd1);
        chk("s4_valid_low", {31'd0, a_valid}, 32'd0);
        chk("s4_count", {27'd0, a_count}, 32'd1);
        chk("s4_addr_hold", {26'd0, a_addr}, 32'h09);
        i_ros_advance = 1'b0;
        tick();
        chk("s4_done_hold", {31'd0, a_done}, 32'd1);
        chk("s4_busy_hold", {31'd0, a_busy}, 32'd1);
        i_ros_advance = 1'b1;
        tick();
        chk("s4_done_clr", {31'd0, a_done}, 32'd0);
        chk("s4_idle", {31'd0, a_busy}, 32'd0);

        // abort on ack of second register
        i_j_reg = 4'd0; i_end_reg = 4'd4; i_start = 1'b1; i_ls_ack = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        chk("s5_req2_addr", {26'd0, a_addr}, 32'h01);
        i_abort = 1'b1;
        tick();
        chk("s5_busy", {31'd0, a_busy}, 32'd0);
        chk("s5_valid", {31'd0, a_valid}, 32'd0);
        chk("s5_done", {31'd0, a_done}, 32'd0);
        chk("s5_count", {27'd0, a_count}, 32'd1);
        i_start = 1'b1;
        tick();
        chk("s5_abort_blocks_start", {31'd0, a_busy}, 32'd0);
        i_start = 1'b0; i_abort = 1'b0;
        tick();

        // async reset between edges during REQ
        i_j_reg = 4'd6; i_end_reg = 4'd8; i_start = 1'b1; i_ls_ack = 1'b0;
        tick();
        i_start = 1'b0;
        chk("s6_pre_valid", {31'd0, a_valid}, 32'd1);
        #1 i_reset = 1'b1;
        #1;
        chk("s6_rst_valid", {31'd0, a_valid}, 32'd0);
        chk("s6_rst_addr",  {26'd0, a_addr},  32'd0);
        chk("s6_rst_busy",  {31'd0, a_busy},  32'd0);
        chk("s6_rst_done",  {31'd0, a_done},  32'd0);
        #1 i_reset = 1'b0;
        tick();
        run_seq(4'd2, 4'd2);
        chk("s6_n", obs_q.size(), 1);
        if (obs_q.size() == 1) chk("s6_addr", {26'd0, obs_q[0]}, 32'h02);
        chk("s6_count", {27'd0, a_count}, 32'd1);
        chk("s6_done", done_cnt, 1);

        // bank parameter
        run_seq(4'd5, 4'd5);
        chk("s7_a_addr", {26'd0, a_addr}, 32'h05);
        chk("s7_b_addr", {26'd0, b_addr}, 32'h25);
        chk("s7_b_count", {27'd0, b_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
